// File: rtl/fusion_unit_ctrl.sv
// Sequencing controller for a bit-fusion multiply unit: accepts a job descriptor,
// streams operand beats into the unit, accumulates partial sums and returns the total.
`timescale 1ns/1ps
module fusion_unit_ctrl #(
   parameter int LEN_W  = 16,
   parameter int PSUM_W = 52
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [3:0]        cfg_in_width,
   input  logic [3:0]        cfg_weight_width,
   input  logic              cfg_s_in,
   input  logic              cfg_s_weight,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [7:0]        op_in,
   input  logic [7:0]        op_weight,
   output logic [7:0]        fu_in,
   output logic [7:0]        fu_weight,
   output logic [3:0]        fu_in_width,
   output logic [3:0]        fu_weight_width,
   output logic              fu_s_in,
   output logic              fu_s_weight,
   output logic [PSUM_W-1:0] fu_psum_in,
   input  logic [PSUM_W-1:0] fu_psum_fwd,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [PSUM_W-1:0] res_psum,
   output logic              cfg_err
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t             state_reg, state_next;
   logic [PSUM_W-1:0]  acc_reg;
   logic [LEN_W-1:0]   remaining_reg;
   logic               stg_v_reg;
   logic [7:0]         stg_in_reg, stg_weight_reg;
   logic [3:0]         in_width_reg, weight_width_reg;
   logic               s_in_reg, s_weight_reg;
   logic               cfg_err_reg;
   logic               cfg_legal, cfg_accept, beat_accept;

   function automatic logic width_legal(input logic [3:0] w);
      return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
   endfunction

   assign cfg_legal   = width_legal(cfg_in_width) && width_legal(cfg_weight_width);
   assign cfg_accept  = cfg_valid && cfg_ready;
   assign beat_accept = op_valid && op_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cfg_ready  = 1'b0;
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid && cfg_legal)
               state_next = (cfg_len == '0) ? FLUSH : RUN;
         end
         RUN: begin
            op_ready = 1'b1;
            if (op_valid && remaining_reg == LEN_W'(1))
               state_next = FLUSH;
         end
         // One extra cycle lets the final staged product land in acc.
         FLUSH: state_next = DONE;
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg          <= '0;
         remaining_reg    <= '0;
         stg_v_reg        <= 1'b0;
         stg_in_reg       <= '0;
         stg_weight_reg   <= '0;
         in_width_reg     <= '0;
         weight_width_reg <= '0;
         s_in_reg         <= 1'b0;
         s_weight_reg     <= 1'b0;
         cfg_err_reg      <= 1'b0;
      end else begin
         cfg_err_reg    <= cfg_accept && !cfg_legal;
         stg_v_reg      <= beat_accept;
         stg_in_reg     <= beat_accept ? op_in : 8'd0;
         stg_weight_reg <= beat_accept ? op_weight : 8'd0;
         if (stg_v_reg) acc_reg <= fu_psum_fwd;
         if (cfg_accept && cfg_legal) begin
            acc_reg          <= '0;
            remaining_reg    <= cfg_len;
            in_width_reg     <= cfg_in_width;
            weight_width_reg <= cfg_weight_width;
            s_in_reg         <= cfg_s_in;
            s_weight_reg     <= cfg_s_weight;
         end else if (beat_accept) begin
            remaining_reg <= remaining_reg - LEN_W'(1);
         end
      end
   end

   assign fu_in           = stg_in_reg;
   assign fu_weight       = stg_weight_reg;
   assign fu_in_width     = in_width_reg;
   assign fu_weight_width = weight_width_reg;
   assign fu_s_in         = s_in_reg;
   assign fu_s_weight     = s_weight_reg;
   assign fu_psum_in      = acc_reg;
   assign res_psum        = (state_reg == DONE) ? acc_reg : '0;
   assign cfg_err         = cfg_err_reg;

endmodule

// File: tb/tb_fusion_unit_ctrl.sv
// Bench for fusion_unit_ctrl: a behavioural fusion unit closes the loop, expected results
// are queued at stimulus time and a monitor checks latency, value and stability.
`timescale 1ns/1ps
module tb_fusion_unit_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid, cfg_ready;
   logic [3:0]  cfg_in_width, cfg_weight_width;
   logic        cfg_s_in, cfg_s_weight;
   logic [15:0] cfg_len;
   logic        op_valid, op_ready;
   logic [7:0]  op_in, op_weight;
   logic [7:0]  fu_in, fu_weight;
   logic [3:0]  fu_in_width, fu_weight_width;
   logic        fu_s_in, fu_s_weight;
   logic [51:0] fu_psum_in, fu_psum_fwd;
   logic        res_valid, res_ready;
   logic [51:0] res_psum;
   logic        cfg_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;

   typedef struct {
      longint psum;
      int     rise;
   } exp_t;
   exp_t sb[$];

   fusion_unit_ctrl #(.LEN_W(16), .PSUM_W(52)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
      .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
      .op_valid(op_valid), .op_ready(op_ready), .op_in(op_in), .op_weight(op_weight),
      .fu_in(fu_in), .fu_weight(fu_weight),
      .fu_in_width(fu_in_width), .fu_weight_width(fu_weight_width),
      .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight),
      .fu_psum_in(fu_psum_in), .fu_psum_fwd(fu_psum_fwd),
      .res_valid(res_valid), .res_ready(res_ready), .res_psum(res_psum),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural fusion unit: one product of the low w bits of each operand.
   function automatic longint ext(input logic [7:0] v, input logic [3:0] w, input logic s);
      longint m;
      int     wi;
      wi = int'(w);
      if (wi == 0) return 0;
      m = longint'(v) & ((longint'(1) << wi) - 1);
      if (s && m[wi-1]) m = m - (longint'(1) << wi);
      return m;
   endfunction

   always_comb
      fu_psum_fwd = fu_psum_in
                  + 52'(ext(fu_in, fu_in_width, fu_s_in) * ext(fu_weight, fu_weight_width, fu_s_weight));

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops on the rising edge of res_valid, then tracks stability until handshake.
   logic   res_prev = 1'b0;
   longint cur_psum = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         res_prev = 1'b0;
      end else begin
         if (res_valid && !res_prev) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_res: got psum %0d with no job pending", res_psum);
            end else begin
               e = sb.pop_front();
               cur_psum = e.psum;
               chk("res_latency", cyc, e.rise);
               chk("res_psum", longint'(res_psum), e.psum);
            end
         end else if (res_valid) begin
            chk("res_stable", longint'(res_psum), cur_psum);
         end
         if (res_valid && res_ready) done_cnt++;
         res_prev = res_valid;
      end
   end

   task automatic send_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                           input logic sw, input logic [15:0] len, output int k);
      cfg_valid = 1'b1; cfg_in_width = iw; cfg_weight_width = ww;
      cfg_s_in = si; cfg_s_weight = sw; cfg_len = len;
      k = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cfg_ready) begin k = cyc; break; end
         @(posedge clk); #1;
      end
      if (k < 0) chk("cfg_timeout", 0, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output int k);
      op_valid = 1'b1; op_in = a; op_weight = b;
      k = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (op_ready) begin k = cyc; break; end
         @(posedge clk); #1;
      end
      if (k < 0) chk("beat_timeout", 0, 1);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 60 && done_cnt < target; i++) @(negedge clk);
      if (done_cnt < target) chk("done_timeout", done_cnt, target);
      @(posedge clk); #1;
   endtask

   task automatic push(input longint psum, input int rise);
      exp_t e;
      e.psum = psum;
      e.rise = rise;
      sb.push_back(e);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_in_width = '0; cfg_weight_width = '0;
      cfg_s_in = 1'b0; cfg_s_weight = 1'b0; cfg_len = '0;
      op_valid = 1'b0; op_in = '0; op_weight = '0; res_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_psum", longint'(res_psum), 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_fu_psum_in", longint'(fu_psum_in), 0);
      chk("rst_fu_in_width", fu_in_width, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // op_valid in IDLE is ignored
      op_valid = 1'b1; op_in = 8'h55; op_weight = 8'h55;
      @(negedge clk);
      chk("idle_op_ready", op_ready, 0);
      @(negedge clk);
      chk("idle_fu_in", fu_in, 0);
      @(posedge clk); #1;
      op_valid = 1'b0;

      // 8x8 unsigned, len 3
      send_cfg(4'd8, 4'd8, 1'b0, 1'b0, 16'd3, k);
      send_beat(8'd255, 8'd255, k);
      send_beat(8'd1, 8'd2, k);
      send_beat(8'd16, 8'd16, k);
      push(65283, k + 2);
      wait_done(1);

      // 8x8 signed, len 2
      send_cfg(4'd8, 4'd8, 1'b1, 1'b1, 16'd2, k);
      send_beat(8'h80, 8'h80, k);
      send_beat(8'h88, 8'h7F, k);
      push(1144, k + 2);
      wait_done(2);

      // Illegal width, then a legal 1x1 job
      send_cfg(4'd3, 4'd8, 1'b0, 1'b0, 16'd1, k);
      @(negedge clk);
      chk("err_pulse", cfg_err, 1);
      chk("err_idle_cfg_ready", cfg_ready, 1);
      chk("err_idle_op_ready", op_ready, 0);
      @(negedge clk);
      chk("err_single_cycle", cfg_err, 0);
      @(posedge clk); #1;
      send_cfg(4'd1, 4'd1, 1'b0, 1'b0, 16'd1, k);
      send_beat(8'd1, 8'd1, k);
      push(1, k + 2);
      wait_done(3);

      // 2x2 len 4 with op_valid gaps and a stalled result
      res_ready = 1'b0;
      send_cfg(4'd2, 4'd2, 1'b0, 1'b0, 16'd4, k);
      send_beat(8'd3, 8'd3, k);
      @(posedge clk); #1;
      send_beat(8'd2, 8'd3, k);
      @(posedge clk); #1;
      send_beat(8'd1, 8'd1, k);
      @(posedge clk); #1;
      send_beat(8'd3, 8'd2, k);
      push(22, k + 2);
      for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_res_valid", res_valid, 1);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      wait_done(4);

      // Zero-length job
      send_cfg(4'd4, 4'd4, 1'b0, 1'b0, 16'd0, k);
      push(0, k + 2);
      wait_done(5);

      // Reset mid-job, then a fresh 4x4 job
      send_cfg(4'd4, 4'd4, 1'b0, 1'b0, 16'd4, k);
      send_beat(8'd1, 8'd1, k);
      send_beat(8'd2, 8'd2, k);
      rst_n = 1'b0;
      #2;
      chk("midrst_fu_psum_in", longint'(fu_psum_in), 0);
      chk("midrst_fu_in", fu_in, 0);
      chk("midrst_op_ready", op_ready, 0);
      chk("midrst_cfg_ready", cfg_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_cfg(4'd4, 4'd4, 1'b0, 1'b0, 16'd1, k);
      send_beat(8'd3, 8'd5, k);
      push(15, k + 2);
      wait_done(6);

      repeat (3) @(posedge clk);
      if (sb.size() != 0) chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fusion_unit_ctrl.md
FUSION_UNIT_CTRL -- requirements
Module: fusion_unit_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, bit width of the job beat count.
REQ-002 SHALL have parameter PSUM_W, default 52, bit width of the fusion-unit partial sum.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port cfg_valid, input, 1, job descriptor valid.
REQ-006 SHALL have port cfg_ready, output, 1, descriptor accepted when cfg_valid and cfg_ready are both high.
REQ-007 SHALL have port cfg_in_width, input, 4, input operand width; legal values 1/2/4/8.
REQ-008 SHALL have port cfg_weight_width, input, 4, weight width; legal values 1/2/4/8.
REQ-009 SHALL have port cfg_s_in and cfg_s_weight, input, 1 each, signedness of the input and weight operands.
REQ-010 SHALL have port cfg_len, input, LEN_W, number of operand beats in the job.
REQ-011 SHALL have port op_valid/op_ready, input/output, 1 each, operand-beat handshake.
REQ-012 SHALL have port op_in and op_weight, input, 8 each, the operand-beat data.
REQ-013 SHALL have port fu_in and fu_weight, output, 8 each; fu_in_width and fu_weight_width, output, 4 each; fu_s_in and fu_s_weight, output, 1 each; fu_psum_in, output, PSUM_W. These drive the fusion unit.
REQ-014 SHALL have port fu_psum_fwd, input, PSUM_W, combinational result from the fusion unit: fu_psum_in plus the packed products.
REQ-015 SHALL have port res_valid/res_ready, output/input, 1 each, result handshake.
REQ-016 SHALL have port res_psum, output, PSUM_W, the final accumulated sum.
REQ-017 SHALL have port cfg_err, output, 1, single-cycle pulse when a descriptor is rejected.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN, FLUSH and DONE.
REQ-019 IDLE: cfg_ready=1 and op_ready=0.
- Legal descriptor: latch all cfg_* fields, clear acc to 0, go to RUN (or FLUSH if cfg_len=0).
- Illegal width: pulse cfg_err for 1 cycle, latch nothing, remain in IDLE.
REQ-020 RUN: op_ready=1 and cfg_ready=0.
- Each op handshake loads op_in/op_weight into the operand stage (stg_v=1) and decrements the remaining count.
- The handshake that takes the count to 0 moves the FSM to FLUSH.
REQ-021 When no beat is accepted in a cycle, stg_v SHALL clear and fu_in/fu_weight SHALL be driven to 0.
REQ-022 In the cycle after any cycle with stg_v=1, acc SHALL be updated to fu_psum_fwd; otherwise acc holds.
REQ-023 fu_psum_in SHALL equal acc; fu_*_width and fu_s_* SHALL equal the latched config in every state.
REQ-024 Throughput SHALL be 1 beat per cycle; op_valid gaps SHALL stall without corrupting acc.
REQ-025 FLUSH: lasts 1 cycle so the last staged product is added, then go to DONE.
REQ-026 DONE: res_valid=1 and res_psum=acc held stable until res_ready; on handshake go to IDLE.
REQ-027 Latency: res_valid SHALL rise exactly 2 cycles after the final op handshake.
REQ-028 A zero-length job SHALL produce res_psum=0 with res_valid 2 cycles after cfg acceptance.
REQ-029 acc SHALL wrap modulo 2^PSUM_W; no saturation and no overflow flag.
REQ-030 Only 1 job SHALL be in flight; cfg_valid outside IDLE SHALL be ignored and left pending.
REQ-031 op_valid outside RUN SHALL be ignored; no beat is consumed.
REQ-032 cfg and res handshakes in the same cycle are impossible by construction; the next descriptor SHALL be accepted no earlier than the cycle after the res handshake.

Reset
REQ-033 rst_n low SHALL immediately force:
- state=IDLE, acc=0, stg_v=0, remaining count=0
- cfg_ready=1, op_ready=0, res_valid=0, res_psum=0, cfg_err=0
- all fu_* outputs=0
REQ-034 Reset asserted mid-job SHALL discard the job; after release the block SHALL accept a fresh descriptor with no residue in acc.

Verification
REQ-035 SHALL cover 8x8 unsigned, len=3, beats (255,255),(1,2),(16,16) -> res_psum=65025+2+256=65283, res_valid 2 cycles after the 3rd beat.
REQ-036 SHALL cover 8x8 signed, len=2, beats (-128,-128),(-120,127) -> res_psum low 16 bits = 16384-15240=1144.
REQ-037 SHALL cover cfg_in_width=3 -> cfg_err pulses for 1 cycle, FSM stays IDLE, then a legal 1x1 len=1 job (1,1) -> res_psum=1.
REQ-038 SHALL cover a len=4 2x2 job with op_valid toggling every other cycle and res_ready held low 5 cycles -> correct sum, res_psum stable while stalled.
REQ-039 SHALL cover cfg_len=0 -> res_psum=0, res_valid 2 cycles after cfg acceptance.
REQ-040 SHALL cover rst_n pulsed low after 2 of 4 beats, then a new len=1 job (3,5) at 4x4 -> res_psum=15.
